// File: rtl/cam_pkg.sv
// Shared definitions for the CAM command scheduler: opcode values, the
// scheduler state encoding and an opcode legality helper.
package cam_pkg;

    localparam int unsigned OP_IDLE       = 0;
    localparam int unsigned OP_UPDATE_ALL = 1;
    localparam int unsigned OP_SEARCH     = 2;
    localparam int unsigned OP_UPDATE_ONE = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } sched_state_e;

    // Only UPDATE_ALL, SEARCH and UPDATE_ONE are ever sent to the CAM.
    function automatic logic op_is_legal(input int unsigned op);
        return (op == OP_UPDATE_ALL) || (op == OP_SEARCH) || (op == OP_UPDATE_ONE);
    endfunction

endpackage

// File: rtl/cam_rr_arbiter.sv
// Combinational round-robin arbiter. Search starts one past last_grant and
// wraps modulo N; outputs a one-hot grant, its binary index and a hit flag.
module cam_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    // First asserted request scanning upward from last_grant+1.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!grant_any && req[IW'(idx)]) begin
                grant[IW'(idx)] = 1'b1;
                grant_idx       = IW'(idx);
                grant_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_cmd_scheduler.sv
// Multi-requester command scheduler in front of the CAM control FSM.
// One command outstanding at a time: pick a requester round-robin, issue the
// opcode once the CAM is idle, wait for the matching end signal, then return
// a completion record.
// Optional build macro CAM_SCHED_TIMEOUT_EN adds a watchdog on the wait phase.
//
// Handshake: a command moves from requester i when req_valid[i] & req_ready[i]
// at a rising clk edge; req_ready is one-hot, combinational, and only ever set
// in S_IDLE. cmd_valid and done_valid are single-cycle strobes with no
// back-pressure.
module cam_cmd_scheduler
    import cam_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int C_DATA_WIDTH   = 512,
    parameter int OP_CODE_WIDTH  = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*OP_CODE_WIDTH-1:0]   req_op,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [OP_CODE_WIDTH-1:0]           cam_state,
    input  logic                               search_end,
    input  logic                               update_all_end,
    output logic [C_DATA_WIDTH-1:0]            cmd_data,
    output logic                               cmd_valid,
    output logic                               done_valid,
    output logic [$clog2(NUM_REQ)-1:0]         done_id,
    output logic [OP_CODE_WIDTH-1:0]           done_op,
    output logic                               done_err,
    output logic                               busy
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || C_DATA_WIDTH < 32 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("cam_cmd_scheduler: parameter out of range");
    end

    sched_state_e             state_q, state_d;
    logic [IW-1:0]            last_grant_q, last_grant_d;
    logic [IW-1:0]            id_q, id_d;
    logic [OP_CODE_WIDTH-1:0] op_q, op_d;
    logic                     err_q, err_d;
    logic                     done_valid_q, done_valid_d;

    logic [NUM_REQ-1:0]       grant;
    logic [IW-1:0]            grant_idx;
    logic                     grant_any;
    logic [OP_CODE_WIDTH-1:0] sel_op;
    logic                     end_match;
    logic                     timed_out;

    cam_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    assign sel_op = req_op[int'(grant_idx)*OP_CODE_WIDTH +: OP_CODE_WIDTH];

    // Only the end signal belonging to the latched opcode completes a command.
    assign end_match = (op_q == OP_CODE_WIDTH'(OP_UPDATE_ALL)) ? update_all_end : search_end;

`ifdef CAM_SCHED_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TCW-1:0] wait_cnt_q, wait_cnt_d;

    // Wait-phase cycle counter: zero outside S_WAIT, so it starts at 0 on entry.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == S_WAIT) begin
            wait_cnt_d = wait_cnt_q + TCW'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign timed_out = (wait_cnt_q == TCW'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    // Next-state and command/accept outputs; a matching end beats the watchdog.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        err_d        = err_q;
        req_ready    = '0;
        cmd_valid    = 1'b0;
        cmd_data     = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = grant;
                if (grant_any) begin
                    id_d = grant_idx;
                    op_d = sel_op;
                    if (op_is_legal(int'(sel_op))) begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (cam_state == '0) begin
                    cmd_valid                      = 1'b1;
                    cmd_data[OP_CODE_WIDTH-1:0]    = op_q;
                    state_d                        = S_WAIT;
                end
            end
            S_WAIT: begin
                if (end_match) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_grant_d = id_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_valid_d = (state_d == S_DONE);
    end

    // State and latched-command registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= IW'(NUM_REQ - 1);
            id_q         <= '0;
            op_q         <= '0;
            err_q        <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            err_q        <= err_d;
            done_valid_q <= done_valid_d;
        end
    end

    assign done_valid = done_valid_q;
    assign done_id    = id_q;
    assign done_op    = op_q;
    assign done_err   = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_cam_cmd_scheduler.sv
// Bench for cam_cmd_scheduler: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level
// model and a completion scoreboard. Honours CAM_SCHED_TIMEOUT_EN.
module tb_cam_cmd_scheduler;

    localparam int N   = 4;
    localparam int DW  = 512;
    localparam int OPW = 3;
    localparam int TO  = 16;
    localparam int IW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N*OPW-1:0]   req_op;
    logic [N-1:0]       req_ready;
    logic [OPW-1:0]     cam_state;
    logic               search_end;
    logic               update_all_end;
    logic [DW-1:0]      cmd_data;
    logic               cmd_valid;
    logic               done_valid;
    logic [IW-1:0]      done_id;
    logic [OPW-1:0]     done_op;
    logic               done_err;
    logic               busy;

    logic cam_search = 1'b0, cam_upd = 1'b0, man_search = 1'b0, man_upd = 1'b0;
    assign search_end     = cam_search | man_search;
    assign update_all_end = cam_upd | man_upd;

    cam_cmd_scheduler #(
        .NUM_REQ        (N),
        .C_DATA_WIDTH   (DW),
        .OP_CODE_WIDTH  (OPW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_ready      (req_ready),
        .cam_state      (cam_state),
        .search_end     (search_end),
        .update_all_end (update_all_end),
        .cmd_data       (cmd_data),
        .cmd_valid      (cmd_valid),
        .done_valid     (done_valid),
        .done_id        (done_id),
        .done_op        (done_op),
        .done_err       (done_err),
        .busy           (busy)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_idx(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- transaction-level model + scoreboard ----------------
    bit               chk_en = 1'b0;
    bit               m_have = 1'b0, m_issued = 1'b0, m_done = 1'b0, m_err = 1'b0;
    int               m_id = 0, m_last = N - 1, m_wait = 0;
    logic [OPW-1:0]   m_op = '0;
    logic [IW+OPW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] e_ready;
            logic         e_cmd, e_done, e_busy, match;
            int           p;
            e_ready = '0; e_cmd = 1'b0; e_done = 1'b0; e_busy = 1'b1;
            p = rr_idx(req_valid, m_last);
            if (m_done) e_done = 1'b1;
            else if (!m_have) begin
                e_busy = 1'b0;
                if (p >= 0) e_ready[p] = 1'b1;
            end else if (!m_issued) e_cmd = (cam_state == 0);
            check("req_ready", 64'(req_ready), 64'(e_ready));
            check("cmd_valid", 64'(cmd_valid), 64'(e_cmd));
            check("done_valid", 64'(done_valid), 64'(e_done));
            check("busy", 64'(busy), 64'(e_busy));
            if (e_cmd) begin
                check("cmd_data", cmd_data[63:0], 64'(m_op));
                check("cmd_data_upper", {63'd0, |cmd_data[DW-1:OPW]}, 64'd0);
            end
            if (e_done) begin
                check("done_id", 64'(done_id), 64'(m_id));
                check("done_op", 64'(done_op), 64'(m_op));
                check("done_err", 64'(done_err), 64'(m_err));
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL scoreboard: completion id %0d with nothing accepted", done_id);
                end else begin
                    check("sb_record", 64'({done_id, done_op}), 64'(exp_q.pop_front()));
                end
            end
            // advance the model across the coming rising edge
            if (rst) begin
                m_have = 0; m_issued = 0; m_done = 0; m_last = N - 1;
                exp_q.delete();
            end else if (m_done) begin
                m_last = m_id; m_done = 0;
            end else if (!m_have) begin
                if (p >= 0) begin
                    m_id = p;
                    m_op = req_op[p*OPW +: OPW];
                    exp_q.push_back({IW'(p), m_op});
                    if (m_op >= 1 && m_op <= 3) begin
                        m_have = 1; m_issued = 0;
                    end else begin
                        m_done = 1; m_err = 1;
                    end
                end
            end else if (!m_issued) begin
                if (cam_state == 0) begin m_issued = 1; m_wait = 0; end
            end else begin
                match = (m_op == 1) ? update_all_end : search_end;
                if (match) begin
                    m_done = 1; m_err = 0; m_have = 0;
                end
`ifdef CAM_SCHED_TIMEOUT_EN
                else if (m_wait == TO - 1) begin
                    m_done = 1; m_err = 1; m_have = 0;
                end
`endif
                else m_wait++;
            end
        end
    end

    // ---------------- CAM responder ----------------
    bit auto_end  = 1'b0;
    int cam_delay = 3;
    initial begin
        bit             pend;
        int             cnt;
        logic [OPW-1:0] pend_op;
        pend = 0; cnt = 0; pend_op = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) pend = 0;
            else if (auto_end && cmd_valid === 1'b1) begin
                pend = 1; cnt = cam_delay - 1; pend_op = cmd_data[OPW-1:0];
            end
            @(posedge clk); #1;
            cam_search = 1'b0; cam_upd = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    pend = 0;
                    if (pend_op == 1) cam_upd = 1'b1; else cam_search = 1'b1;
                end else cnt--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        req_valid = '0; man_search = 0; man_upd = 0; cam_state = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input int op);
        req_valid[i] = 1'b1;
        req_op[i*OPW +: OPW] = OPW'(op);
    endtask

    task automatic wait_ready(input int i, input string name);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ready[i] === 1'b1) return;
        end
        n_checks++; n_fail++;
        $display("FAIL %s: req_ready[%0d] not seen within 50 cycles", name, i);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int grants[5];
        int ng;
        logic [N-1:0] acc;
        req_valid = '0; req_op = '0; cam_state = '0; rst = 1'b1;
        tick(); tick();
        rst = 1'b0; chk_en = 1'b1;

        // reset values
        @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_ready", 64'(req_ready), 0);
        check("rst_cmd_valid", 64'(cmd_valid), 0);
        check("rst_cmd_data", cmd_data[63:0], 0);
        check("rst_done", 64'({done_valid, done_id, done_op, done_err}), 0);

        // single SEARCH from requester 2, end 5 cycles after issue
        do_reset();
        set_req(2, 2);
        wait_ready(2, "t1_accept");
        check("t1_ready", 64'(req_ready), 64'h4);
        tick(); req_valid = '0;
        @(negedge clk);
        check("t1_cmd_valid", 64'(cmd_valid), 1);
        check("t1_cmd_data", 64'(cmd_data[31:0]), 2);
        repeat (5) tick();
        man_search = 1'b1;
        @(negedge clk);
        check("t1_no_early_done", 64'(done_valid), 0);
        tick(); man_search = 1'b0;
        @(negedge clk);
        check("t1_done", 64'({done_valid, done_id, done_op, done_err}), 64'({1'b1, 2'd2, 3'd2, 1'b0}));

        // four requesters, UPDATE_ALL, round-robin order
        do_reset();
        auto_end = 1; cam_delay = 3;
        for (int i = 0; i < N; i++) set_req(i, 1);
        ng = 0;
        for (int c = 0; c < 200 && ng < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) begin grants[ng] = i; ng++; end
        end
        check("t2_grant_count", 64'(ng), 5);
        check("t2_g0", 64'(grants[0]), 0);
        check("t2_g1", 64'(grants[1]), 1);
        check("t2_g2", 64'(grants[2]), 2);
        check("t2_g3", 64'(grants[3]), 3);
        check("t2_g4", 64'(grants[4]), 0);
        tick(); req_valid = '0; auto_end = 0;
        repeat (10) tick();

        // UPDATE_ONE from requester 1 while CAM is busy; early end ignored
        do_reset();
        cam_state = 3'd1;
        set_req(1, 3);
        wait_ready(1, "t3_accept");
        check("t3_ready", 64'(req_ready), 64'h2);
        tick(); req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            man_search = (k == 2);
            @(negedge clk);
            check("t3_stall", 64'(cmd_valid), 0);
            tick();
        end
        man_search = 1'b0; cam_state = '0;
        @(negedge clk);
        check("t3_cmd_valid", 64'(cmd_valid), 1);
        check("t3_cmd_data", 64'(cmd_data[31:0]), 3);
        tick(); tick(); tick(); man_search = 1'b1;
        @(negedge clk);
        check("t3_no_early_done", 64'(done_valid), 0);
        tick(); man_search = 1'b0;
        @(negedge clk);
        check("t3_done", 64'({done_valid, done_id, done_op, done_err}), 64'({1'b1, 2'd1, 3'd3, 1'b0}));

        // illegal opcode 0 from requester 0
        do_reset();
        set_req(0, 0);
        wait_ready(0, "t4_accept");
        check("t4_ready", 64'(req_ready), 64'h1);
        tick(); req_valid = '0;
        @(negedge clk);
        check("t4_cmd_valid", 64'(cmd_valid), 0);
        check("t4_done", 64'({done_valid, done_id, done_op, done_err}), 64'({1'b1, 2'd0, 3'd0, 1'b1}));

        // SEARCH with no end: watchdog (or indefinite wait)
        do_reset();
        set_req(2, 2);
        wait_ready(2, "t5_accept");
        tick(); req_valid = '0;
        @(negedge clk);
        check("t5_cmd_valid", 64'(cmd_valid), 1);
`ifdef CAM_SCHED_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            tick();
            @(negedge clk);
            check("t5_wait_no_done", 64'(done_valid), 0);
        end
        tick();
        set_req(3, 1);
        @(negedge clk);
        check("t5_timeout_done", 64'({done_valid, done_id, done_op, done_err}), 64'({1'b1, 2'd2, 3'd2, 1'b1}));
        tick();
        @(negedge clk);
        check("t5_next_accept", 64'(req_ready), 64'h8);
        tick(); req_valid = '0;
`else
        repeat (30) tick();
        @(negedge clk);
        check("t5_still_waiting", 64'({busy, done_valid}), 64'h2);
`endif

        // reset while waiting
        do_reset();
        set_req(3, 2);
        wait_ready(3, "t6_accept");
        tick(); req_valid = '0;
        @(negedge clk);
        check("t6_cmd_valid", 64'(cmd_valid), 1);
        tick(); tick(); rst = 1'b1;
        @(negedge clk);
        check("t6_busy_before", 64'(busy), 1);
        tick(); rst = 1'b0;
        @(negedge clk);
        check("t6_outputs_zero", 64'({busy, cmd_valid, done_valid, done_id, done_op, done_err, req_ready}), 0);
        check("t6_cmd_data_zero", cmd_data[63:0], 0);
        tick();
        for (int i = 0; i < N; i++) set_req(i, 2);
        @(negedge clk);
        check("t6_first_grant", 64'(req_ready), 64'h1);
        tick(); req_valid = '0;

        // randomized traffic
        do_reset();
        auto_end = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) set_req(i, $urandom_range(0, 7));
                    else req_valid[i] = 1'b0;
                end
            end
            cam_state  = ($urandom_range(0, 3) == 0) ? OPW'($urandom_range(1, 7)) : '0;
            man_search = ($urandom_range(0, 15) == 0);
            man_upd    = ($urandom_range(0, 15) == 0);
            cam_delay  = $urandom_range(1, 7);
            rst        = ($urandom_range(0, 599) == 0);
        end
        req_valid = '0; man_search = 0; man_upd = 0; rst = 0; cam_state = '0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
